// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM states and access-size masks for the load/store unit.
// Pure definitions: no latency, no handshake.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] SIZE_MASK_B = 4'b0001;
  localparam logic [3:0] SIZE_MASK_H = 4'b0011;
  localparam logic [3:0] SIZE_MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC1,
    ST_ACC2,
    ST_FIN
  } lsu_state_t;

  // Access width in bytes; 0 marks an encoding no load or store uses.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_bytes = 3'd1;
      F3_H, F3_HU: access_bytes = 3'd2;
      F3_W:        access_bytes = 3'd4;
      default:     access_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, shifted store data, split/illegal decode, load merge+extend.
// Zero latency; no handshake of its own.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  output logic [3:0]  be1,
  output logic [3:0]  be2,
  output logic [31:0] wdata1,
  output logic [31:0] wdata2,
  output logic        split,
  output logic        illegal,
  output logic [31:0] load_result
);

  logic [2:0]  nbytes;
  logic [3:0]  size_mask;
  logic [7:0]  mask;
  logic [63:0] shifted_wdata;
  logic [31:0] r;

  always_comb begin
    nbytes = access_bytes(funct3);
    case (nbytes)
      3'd1:    size_mask = SIZE_MASK_B;
      3'd2:    size_mask = SIZE_MASK_H;
      3'd4:    size_mask = SIZE_MASK_W;
      default: size_mask = 4'b0000;
    endcase

    // Any enable spilling into the upper nibble means the access crosses a word.
    mask    = {4'b0000, size_mask} << offset;
    be1     = mask[3:0];
    be2     = mask[7:4];
    split   = |mask[7:4];
    illegal = (nbytes == 3'd0) || (is_store && funct3[2]);

    shifted_wdata = {32'h0, store_data} << {offset, 3'b000};
    wdata1        = shifted_wdata[31:0];
    wdata2        = shifted_wdata[63:32];

    r = 32'({(split ? rdata2 : 32'h0), rdata1} >> {offset, 3'b000});
    case (funct3)
      F3_B:    load_result = {{24{r[7]}}, r[7:0]};
      F3_BU:   load_result = {24'h0, r[7:0]};
      F3_H:    load_result = {{16{r[15]}}, r[15:0]};
      F3_HU:   load_result = {16'h0, r[15:0]};
      default: load_result = r;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit on a word bus; done 3 cycles after start (4 when split) with zero-wait ack.
// Request held stable until mem_ack; waits indefinitely; start only accepted when idle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  lsu_state_t  state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] address_q;
  logic [1:0]  offset_q;
  logic [31:0] store_data_q;
  logic [31:0] rdata1_q;
  logic        err_q;

  logic        idle;
  logic        a_is_store;
  logic [2:0]  a_funct3;
  logic [1:0]  a_offset;
  logic [31:0] rd1;
  logic [3:0]  be1, be2;
  logic [31:0] wdata1, wdata2, load_result;
  logic        split, illegal, reject;

  // Decode the live inputs while idle so the accept decision is made on the start cycle.
  assign idle       = (state_q == ST_IDLE);
  assign a_is_store = idle ? is_store : is_store_q;
  assign a_funct3   = idle ? funct3   : funct3_q;
  assign a_offset   = idle ? offset   : offset_q;
  assign rd1        = (state_q == ST_ACC1) ? mem_rdata : rdata1_q;
  assign reject     = illegal || (split && (SPLIT_MISALIGNED == 0));

  lsu_align u_align (
    .is_store    (a_is_store),
    .funct3      (a_funct3),
    .offset      (a_offset),
    .store_data  (store_data_q),
    .rdata1      (rd1),
    .rdata2      (mem_rdata),
    .be1         (be1),
    .be2         (be2),
    .wdata1      (wdata1),
    .wdata2      (wdata2),
    .split       (split),
    .illegal     (illegal),
    .load_result (load_result)
  );

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = reject ? ST_FIN : ST_ACC1;
      end
      ST_ACC1: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = address_q;
        mem_be    = be1;
        mem_wdata = is_store_q ? wdata1 : 32'h0;
        if (mem_ack) state_d = split ? ST_ACC2 : ST_FIN;
      end
      ST_ACC2: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = address_q + 32'd4;
        mem_be    = be2;
        mem_wdata = is_store_q ? wdata2 : 32'h0;
        if (mem_ack) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = !err_q;
        error   = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      address_q    <= 32'h0;
      offset_q     <= 2'b00;
      store_data_q <= 32'h0;
      rdata1_q     <= 32'h0;
      err_q        <= 1'b0;
      load_data    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (idle && start) begin
        is_store_q   <= is_store;
        funct3_q     <= funct3;
        address_q    <= address & 32'hFFFF_FFFC;
        offset_q     <= offset;
        store_data_q <= store_data;
        err_q        <= reject;
      end
      if ((state_q == ST_ACC1) && mem_ack) rdata1_q <= mem_rdata;
      // Result lands on the final ack edge so it is already valid during FIN.
      if (!is_store_q && mem_ack &&
          (((state_q == ST_ACC1) && !split) || (state_q == ST_ACC2)))
        load_data <= load_result;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed memory model behind the bus plus a byte-level
// reference model of RV32I loads/stores; a second instance covers the no-split variant.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = 32'h0, store_data = 32'h0;
  logic [1:0]  offset = 2'b00;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy, done, error, mem_req, mem_we;
  logic        mem_ack = 1'b0;
  logic [3:0]  mem_be;

  logic        start_ns = 1'b0;
  logic [31:0] load_data_ns, mem_addr_ns, mem_wdata_ns;
  logic        busy_ns, done_ns, error_ns, mem_req_ns, mem_we_ns, mem_ack_ns;
  logic [3:0]  mem_be_ns;
  logic [31:0] mem_rdata_ns;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.SPLIT_MISALIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .address(address), .offset(offset), .store_data(store_data), .load_data(load_data),
    .busy(busy), .done(done), .error(error), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  assign mem_ack_ns   = mem_req_ns;
  assign mem_rdata_ns = 32'hCAFE_F00D;

  load_store_unit #(.SPLIT_MISALIGNED(0)) u_nosplit (
    .clk(clk), .rst(rst), .start(start_ns), .is_store(is_store), .funct3(funct3),
    .address(address), .offset(offset), .store_data(store_data), .load_data(load_data_ns),
    .busy(busy_ns), .done(done_ns), .error(error_ns), .mem_req(mem_req_ns), .mem_we(mem_we_ns),
    .mem_addr(mem_addr_ns), .mem_be(mem_be_ns), .mem_wdata(mem_wdata_ns),
    .mem_rdata(mem_rdata_ns), .mem_ack(mem_ack_ns)
  );

  // ---------------- memory (bus side) and reference model (byte side) ----------------
  logic [7:0] mem_b [logic [31:0]];
  logic [7:0] exp_b [logic [31:0]];

  function automatic logic [7:0] init_b(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return init_b(a);
  endfunction
  function automatic logic [7:0] exp_rd(input logic [31:0] a);
    if (exp_b.exists(a)) return exp_b[a];
    return init_b(a);
  endfunction
  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem_b[a + 32'(i)] = w[8*i +: 8];
      exp_b[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Little-endian read of the accessed bytes, then RV32I extension rule.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < ref_size(f3); k++) v[8*k +: 8] = exp_rd(a + 32'(k));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // ---------------- bus responder ----------------
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic [68:0] snap;
  logic [31:0] q_addr[$], q_wdata[$];
  logic [3:0]  q_be[$];
  logic        q_we[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (mem_req) begin
        if (wcnt == 0) snap = {mem_addr, mem_be, mem_we, mem_wdata};
        else begin
          n_tests++;
          if ({mem_addr, mem_be, mem_we, mem_wdata} !== snap) begin
            n_fail++;
            $display("FAIL req_stable: got %h want %h", {mem_addr, mem_be, mem_we, mem_wdata}, snap);
          end
        end
        if (wcnt >= wait_cycles) begin
          mem_ack = 1'b1;
          for (int i = 0; i < 4; i++) begin
            mem_rdata[8*i +: 8] = mem_rd(mem_addr + 32'(i));
            if (mem_we && mem_be[i]) mem_b[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
          end
          q_addr.push_back(mem_addr); q_be.push_back(mem_be);
          q_we.push_back(mem_we);     q_wdata.push_back(mem_wdata);
          wcnt = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // ---------------- one operation: drive, wait bounded, record ----------------
  int          r_cycles;
  logic        r_done, r_err, r_busy_ok;
  logic [31:0] r_ld;
  logic [3:0]  r_tail;
  logic [31:0] last_ld = 32'h0;

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [1:0] off, input logic [31:0] sd, input int w);
    int c;
    bit fin;
    q_addr.delete(); q_be.delete(); q_we.delete(); q_wdata.delete();
    wait_cycles = w;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; address = addr; offset = off; store_data = sd;
    c = 1; fin = 0; r_done = 0; r_err = 0; r_busy_ok = 1; r_ld = 32'hx;
    while (!fin && c < 60) begin
      @(negedge clk);
      c++;
      // Inputs after acceptance must not matter; start here lands in ACC/FIN and is ignored.
      start = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
      address = $urandom; offset = 2'($urandom); store_data = $urandom;
      if (done || error) begin
        fin = 1; r_done = done; r_err = error; r_ld = load_data;
      end else if (!busy) r_busy_ok = 0;
    end
    r_cycles = c;
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL op_timeout: no done/error after %0d cycles", c);
    end
    @(negedge clk);
    start = 1'b0;
    r_tail = {done, error, busy, mem_req};
    @(negedge clk);
    r_tail = r_tail | {done, error, busy, mem_req};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;
    n_tests++;
    if ({load_data, mem_addr, mem_be, mem_wdata, mem_req, mem_we, busy, done, error} !== 101'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ld=%h addr=%h be=%b wd=%h req=%b we=%b busy=%b done=%b err=%b want all 0",
               load_data, mem_addr, mem_be, mem_wdata, mem_req, mem_we, busy, done, error);
    end
    n_tests++;
    if ({load_data_ns, mem_addr_ns, mem_be_ns, mem_wdata_ns, mem_req_ns, mem_we_ns, busy_ns, done_ns, error_ns} !== 101'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_ns: got ld=%h addr=%h be=%b req=%b want all 0",
               load_data_ns, mem_addr_ns, mem_be_ns, mem_req_ns);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    // LW aligned, zero wait
    set_word(32'h100, 32'h8899_AABB);
    do_op(1'b0, 3'b010, 32'h100, 2'd0, 32'h0, 0);
    n_tests++;
    if (r_cycles !== 3 || r_done !== 1'b1 || q_addr.size() !== 1) begin
      n_fail++; $display("FAIL lw_timing: cycles=%0d done=%b txns=%0d want 3/1/1", r_cycles, r_done, q_addr.size());
    end
    n_tests++;
    if (q_be.size() != 1 || q_be[0] !== 4'b1111 || r_ld !== 32'h8899_AABB) begin
      n_fail++; $display("FAIL lw_data: be=%b ld=%h want 1111 8899aabb", (q_be.size() != 0) ? q_be[0] : 4'hx, r_ld);
    end
    n_tests++;
    if (r_tail !== 4'b0000 || r_busy_ok !== 1'b1) begin
      n_fail++; $display("FAIL lw_pulse: tail=%b busy_ok=%b want 0000 1", r_tail, r_busy_ok);
    end
    // LB / LBU at offset 2
    set_word(32'h300, 32'h00F3_0000);
    do_op(1'b0, 3'b000, 32'h300, 2'd2, 32'h0, 0);
    n_tests++;
    if (q_be.size() != 1 || q_be[0] !== 4'b0100 || r_ld !== 32'hFFFF_FFF3) begin
      n_fail++; $display("FAIL lb_sext: be=%b ld=%h want 0100 fffffff3", (q_be.size() != 0) ? q_be[0] : 4'hx, r_ld);
    end
    do_op(1'b0, 3'b100, 32'h300, 2'd2, 32'h0, 0);
    n_tests++;
    if (r_ld !== 32'h0000_00F3) begin
      n_fail++; $display("FAIL lbu_zext: ld=%h want 000000f3", r_ld);
    end
    // SH split at offset 3
    do_op(1'b1, 3'b001, 32'h200, 2'd3, 32'h0000_BEEF, 0);
    n_tests++;
    if (q_addr.size() != 2 || r_cycles !== 4 || r_done !== 1'b1) begin
      n_fail++; $display("FAIL sh_split_count: txns=%0d cycles=%0d want 2 4", q_addr.size(), r_cycles);
    end else begin
      n_tests++;
      if (q_addr[0] !== 32'h200 || q_be[0] !== 4'b1000 || q_wdata[0][31:24] !== 8'hEF || q_we[0] !== 1'b1 ||
          q_addr[1] !== 32'h204 || q_be[1] !== 4'b0001 || q_wdata[1][7:0] !== 8'hBE || q_we[1] !== 1'b1) begin
        n_fail++; $display("FAIL sh_split_txn: %h/%b/%h %h/%b/%h want 200/1000/EF.. 204/0001/..BE",
                           q_addr[0], q_be[0], q_wdata[0], q_addr[1], q_be[1], q_wdata[1]);
      end
    end
    // LW split at offset 2 with two wait cycles per ack
    set_word(32'h400, 32'h3344_5566);
    set_word(32'h404, 32'h7788_1122);
    do_op(1'b0, 3'b010, 32'h400, 2'd2, 32'h0, 2);
    n_tests++;
    if (r_ld !== 32'h1122_3344 || r_cycles !== 8) begin
      n_fail++; $display("FAIL lw_split_wait: ld=%h cycles=%0d want 11223344 8", r_ld, r_cycles);
    end
    last_ld = 32'h1122_3344;
    // Illegal funct3
    do_op(1'b0, 3'b011, 32'h100, 2'd0, 32'h0, 0);
    n_tests++;
    if (r_err !== 1'b1 || r_done !== 1'b0 || q_addr.size() !== 0 || r_cycles !== 2 || load_data !== last_ld) begin
      n_fail++; $display("FAIL illegal_f3: err=%b done=%b txns=%0d cycles=%0d ld=%h want 1 0 0 2 %h",
                         r_err, r_done, q_addr.size(), r_cycles, load_data, last_ld);
    end
    // Split across the top of the address space
    set_word(32'hFFFF_FFFC, 32'hA1B2_C3D4);
    set_word(32'h0000_0000, 32'h5566_7788);
    do_op(1'b0, 3'b010, 32'hFFFF_FFFC, 2'd1, 32'h0, 0);
    n_tests++;
    if (q_addr.size() != 2 || q_addr[1] !== 32'h0 || r_ld !== 32'h88A1_B2C3) begin
      n_fail++; $display("FAIL addr_wrap: txns=%0d ld=%h want 2 88a1b2c3", q_addr.size(), r_ld);
    end
    last_ld = r_ld;
  endtask

  task automatic test_random;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr, sd, ea, e_ld;
    logic [63:0] e_w;
    logic [3:0]  ebe;
    logic [1:0]  off;
    bit          legal, spl, bad;
    int          n, w, lane;
    for (int it = 0; it < 60; it++) begin
      st   = 1'($urandom);
      f3   = ($urandom_range(0, 9) < 8) ? (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5))) : 3'($urandom);
      addr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      if (it % 15 == 7) addr = 32'hFFFF_FFF8;
      off  = 2'($urandom);
      sd   = $urandom;
      w    = $urandom_range(0, 2);
      n    = ref_size(f3);
      legal = (n != 0) && !(st && f3[2]);
      spl   = (int'(off) + n) > 4;
      ea    = addr + 32'(off);
      e_ld  = st ? last_ld : ref_load(f3, ea);
      do_op(st, f3, addr, off, sd, w);
      n_tests++;
      if (!legal) begin
        if (r_err !== 1'b1 || r_done !== 1'b0 || q_addr.size() != 0 || r_cycles != 2 || load_data !== last_ld) begin
          n_fail++; $display("FAIL rand_illegal[%0d]: err=%b done=%b txns=%0d cycles=%0d", it, r_err, r_done, q_addr.size(), r_cycles);
        end
        continue;
      end
      if (r_done !== 1'b1 || r_err !== 1'b0 || r_cycles != (spl ? 4 + 2*w : 3 + w) || q_addr.size() != (spl ? 2 : 1)
          || r_tail !== 4'b0000 || r_busy_ok !== 1'b1) begin
        n_fail++; $display("FAIL rand_flow[%0d]: done=%b cycles=%0d txns=%0d tail=%b want split=%0d wait=%0d",
                           it, r_done, r_cycles, q_addr.size(), r_tail, spl, w);
        continue;
      end
      e_w = st ? ({32'h0, sd} << (8 * int'(off))) : 64'h0;
      bad = 0;
      for (int t = 0; t < q_addr.size(); t++) begin
        ebe = 4'h0;
        for (int k = 0; k < n; k++) begin
          lane = int'(off) + k;
          if (lane / 4 == t) ebe[lane % 4] = 1'b1;
        end
        if (q_addr[t] !== addr + 32'(4 * t) || q_be[t] !== ebe || q_we[t] !== st || q_wdata[t] !== e_w[32*t +: 32]) begin
          bad = 1;
          $display("FAIL rand_txn[%0d.%0d]: addr=%h be=%b we=%b wd=%h want %h %b %b %h", it, t,
                   q_addr[t], q_be[t], q_we[t], q_wdata[t], addr + 32'(4 * t), ebe, st, e_w[32*t +: 32]);
        end
      end
      n_tests++;
      if (bad) n_fail++;
      if (st) for (int k = 0; k < n; k++) exp_b[ea + 32'(k)] = sd[8*k +: 8];
      bad = 0;
      for (int i = 0; i < 8; i++) if (mem_rd(addr + 32'(i)) !== exp_rd(addr + 32'(i))) bad = 1;
      n_tests++;
      if (bad || r_ld !== e_ld || load_data !== e_ld) begin
        n_fail++; $display("FAIL rand_data[%0d]: ld=%h want %h mem_ok=%0d", it, r_ld, e_ld, !bad);
      end
      last_ld = e_ld;
    end
  endtask

  task automatic test_reset_abort;
    bit saw;
    set_word(32'h500, 32'h0BAD_F00D);
    wait_cycles = 20;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; address = 32'h500; offset = 2'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre: req=%b busy=%b want 1 1", mem_req, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || load_data !== 32'h0) begin
      n_fail++; $display("FAIL abort_async: req=%b busy=%b addr=%h be=%b ld=%h want 0", mem_req, busy, mem_addr, mem_be, load_data);
    end
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || error || mem_req || busy) saw = 1;
    end
    n_tests++;
    if (saw) begin
      n_fail++; $display("FAIL abort_quiet: activity after reset, want none");
    end
    last_ld = 32'h0;
    do_op(1'b0, 3'b010, 32'h500, 2'd0, 32'h0, 1);
    n_tests++;
    if (r_done !== 1'b1 || r_ld !== 32'h0BAD_F00D || r_cycles != 4) begin
      n_fail++; $display("FAIL abort_recover: done=%b ld=%h cycles=%0d want 1 0badf00d 4", r_done, r_ld, r_cycles);
    end
  endtask

  task automatic run_ns(input logic [2:0] f3, input logic [1:0] off, output int cyc,
                        output logic got_done, output logic got_err, output logic saw_req);
    @(negedge clk);
    start_ns = 1'b1; is_store = 1'b0; funct3 = f3; address = 32'h600; offset = off;
    cyc = 1; got_done = 0; got_err = 0; saw_req = 0;
    while (!(got_done || got_err) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start_ns = 1'b0;
      if (mem_req_ns) saw_req = 1;
      got_done = done_ns;
      got_err  = error_ns;
    end
  endtask

  task automatic test_no_split;
    int   cyc;
    logic d, e, rq;
    run_ns(3'b010, 2'd1, cyc, d, e, rq);
    n_tests++;
    if (e !== 1'b1 || d !== 1'b0 || rq !== 1'b0 || cyc != 2) begin
      n_fail++; $display("FAIL nosplit_lw_off1: err=%b done=%b req=%b cycles=%0d want 1 0 0 2", e, d, rq, cyc);
    end
    run_ns(3'b101, 2'd3, cyc, d, e, rq);
    n_tests++;
    if (e !== 1'b1 || rq !== 1'b0) begin
      n_fail++; $display("FAIL nosplit_lhu_off3: err=%b req=%b want 1 0", e, rq);
    end
    run_ns(3'b000, 2'd1, cyc, d, e, rq);
    n_tests++;
    if (d !== 1'b1 || e !== 1'b0 || cyc != 3 || load_data_ns !== 32'hFFFF_FFF0) begin
      n_fail++; $display("FAIL nosplit_lb_aligned: done=%b err=%b cycles=%0d ld=%h want 1 0 3 fffffff0", d, e, cyc, load_data_ns);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_no_split();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
